// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bp_pkg
// Desc     : Shared record layout and player state encoding for the branch
//            trace player and its gshare predictor.
// Revision : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int PC_W = 8;

    // Trace record is {pc, outcome}: outcome in bit 0, pc directly above it.
    localparam int REC_OUT_BIT = 0;
    localparam int REC_PC_LSB  = 1;
    localparam int REC_PC_MSB  = REC_PC_LSB + PC_W - 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DONE  = 3'd4
    } player_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Desc     : Up-counter with synchronous clear that sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_trace_player.sv
`default_nettype none
// ============================================================================
// Module   : branch_trace_player
// Desc     : Replays {pc, outcome} records from an external trace memory into
//            a branch predictor and scores branches and mispredictions.
// Revision : 1.0 - initial release
// ============================================================================
module branch_trace_player
    import bp_pkg::*;
#(
    parameter int PC_W   = bp_pkg::PC_W,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   trace_len,
    output logic              trace_rd_en,
    output logic [ADDR_W-1:0] trace_addr,
    input  logic [PC_W:0]     trace_data,
    output logic              predict_enable,
    output logic [PC_W-1:0]   branch_pc,
    output logic              actual_outcome,
    input  logic              prediction,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  num_branches,
    output logic [CNT_W-1:0]  num_mispredictions
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    player_state_t   state;
    logic [ADDR_W:0] idx;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] idx_next;
    logic [ADDR_W:0] len_clamped;
    logic            start_ok;
    logic            issue;
    logic            mispredict;

    assign start_ok    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign len_clamped = (trace_len > MAX_LEN) ? MAX_LEN : trace_len;
    assign issue       = (state == ST_ISSUE);
    assign idx_next    = idx + (ADDR_W + 1)'(1);
    assign mispredict  = issue && (prediction != actual_outcome);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            idx            <= '0;
            len_q          <= '0;
            branch_pc      <= '0;
            actual_outcome <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        len_q <= len_clamped;
                        idx   <= '0;
                        state <= (len_clamped != '0) ? ST_FETCH : ST_DONE;
                    end
                end
                ST_FETCH: begin
                    state <= ST_WAIT;
                end
                // Memory data is valid this cycle, one cycle after the read strobe.
                ST_WAIT: begin
                    branch_pc      <= trace_data[REC_PC_LSB +: PC_W];
                    actual_outcome <= trace_data[REC_OUT_BIT];
                    state          <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    idx   <= idx_next;
                    state <= (idx_next == len_q) ? ST_DONE : ST_FETCH;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign trace_rd_en    = (state == ST_FETCH);
    assign trace_addr     = idx[ADDR_W-1:0];
    assign predict_enable = issue;
    assign busy           = (state == ST_FETCH) || (state == ST_WAIT) || (state == ST_ISSUE);
    assign done           = (state == ST_DONE);

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start_ok),
        .inc   (issue),
        .count (num_branches)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_mispredict_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start_ok),
        .inc   (mispredict),
        .count (num_mispredictions)
    );

endmodule
`default_nettype wire

// File: tb/tb_branch_trace_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_trace_player
// Desc     : Record-level reference model and scorer for branch_trace_player.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_trace_player;

    localparam int PC_W   = 8;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic              start     = 1'b0;
    logic [ADDR_W:0]   trace_len = '0;
    logic              trace_rd_en;
    logic [ADDR_W-1:0] trace_addr;
    logic [PC_W:0]     trace_data = '0;
    logic              predict_enable;
    logic [PC_W-1:0]   branch_pc;
    logic              actual_outcome;
    logic              prediction;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  num_branches;
    logic [CNT_W-1:0]  num_mispredictions;

    logic              start_s     = 1'b0;
    logic [ADDR_W:0]   trace_len_s = '0;
    logic              rd_en_s;
    logic [ADDR_W-1:0] addr_s;
    logic [PC_W:0]     data_s = '0;
    logic              pe_s;
    logic [PC_W-1:0]   pc_s;
    logic              out_s;
    logic              busy_s;
    logic              done_s;
    logic [1:0]        nb_s;
    logic [1:0]        nm_s;

    int total = 0;
    int bad   = 0;

    branch_trace_player #(.PC_W(PC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .trace_len(trace_len),
        .trace_rd_en(trace_rd_en), .trace_addr(trace_addr), .trace_data(trace_data),
        .predict_enable(predict_enable), .branch_pc(branch_pc),
        .actual_outcome(actual_outcome), .prediction(prediction),
        .busy(busy), .done(done), .num_branches(num_branches),
        .num_mispredictions(num_mispredictions)
    );

    branch_trace_player #(.PC_W(PC_W), .ADDR_W(ADDR_W), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .trace_len(trace_len_s),
        .trace_rd_en(rd_en_s), .trace_addr(addr_s), .trace_data(data_s),
        .predict_enable(pe_s), .branch_pc(pc_s), .actual_outcome(out_s),
        .prediction(1'b0), .busy(busy_s), .done(done_s),
        .num_branches(nb_s), .num_mispredictions(nm_s)
    );

    // Shared behavioural ROM, one-cycle read latency per port.
    logic [PC_W:0] rom [DEPTH];
    always @(posedge clk) begin
        if (trace_rd_en) trace_data <= rom[trace_addr];
        if (rd_en_s)     data_s     <= rom[addr_s];
    end

    int pe_count = 0;
    int rd_count = 0;
    always @(posedge clk) begin
        if (predict_enable) pe_count <= pe_count + 1;
        if (trace_rd_en)    rd_count <= rd_count + 1;
    end

    // Predictor environment: constant 1, constant 0, or a small gshare.
    int         pmode  = 0;
    logic       gs_clr = 1'b1;
    logic [1:0] lpht [16];
    logic [3:0] lghr;
    logic [3:0] lgi;

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? c : c + 2'd1;
        return (c == 2'd0) ? c : c - 2'd1;
    endfunction

    assign lgi        = branch_pc[3:0] ^ lghr;
    assign prediction = (pmode == 0) ? 1'b1 : (pmode == 1) ? 1'b0 : lpht[lgi][1];

    always @(posedge clk) begin
        if (gs_clr) begin
            for (int i = 0; i < 16; i++) lpht[i] <= 2'd0;
            lghr <= 4'd0;
        end else if (predict_enable && (pmode == 2)) begin
            lpht[lgi] <= sat2(lpht[lgi], actual_outcome);
            lghr      <= {lghr[2:0], actual_outcome};
        end
    end

    // Reference model: a run of n records is a list of issues at cycles 3k+3.
    int             m_mode = 0;
    int             m_t    = 0;
    int             m_n    = 0;
    logic [PC_W-1:0] m_pc  [DEPTH];
    logic           m_out  [DEPTH];
    int             m_misb [DEPTH+1];
    logic [1:0]     mpht   [16];
    logic [3:0]     mghr;

    task automatic plan(input int len);
        logic       p;
        logic [3:0] i;
        m_n       = (len > DEPTH) ? DEPTH : len;
        m_misb[0] = 0;
        for (int k = 0; k < m_n; k++) begin
            m_pc[k]  = rom[k][PC_W:1];
            m_out[k] = rom[k][0];
            if (pmode == 0) begin
                p = 1'b1;
            end else if (pmode == 1) begin
                p = 1'b0;
            end else begin
                i       = m_pc[k][3:0] ^ mghr;
                p       = mpht[i][1];
                mpht[i] = sat2(mpht[i], m_out[k]);
                mghr    = {mghr[2:0], m_out[k]};
            end
            m_misb[k+1] = m_misb[k] + ((p != m_out[k]) ? 1 : 0);
        end
    endtask

    always @(posedge clk) begin
        if (gs_clr) begin
            for (int i = 0; i < 16; i++) mpht[i] = 2'd0;
            mghr = 4'd0;
        end
        if (reset) begin
            m_mode = 0;
            m_t    = 0;
        end else if (start && ((m_mode == 0) || (m_t >= 3 * m_n + 1))) begin
            plan(int'(trace_len));
            m_mode = 1;
            m_t    = 1;
        end else if (m_mode == 1) begin
            m_t = m_t + 1;
        end
    end

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", what, act, exp, $time);
        end
    endtask

    function automatic int sat(input int x);
        int mx;
        mx = (1 << CNT_W) - 1;
        return (x > mx) ? mx : x;
    endfunction

    always @(negedge clk) begin : cmp
        int k;
        int ph;
        if (m_mode == 0) begin
            chk("idle_rd_en", trace_rd_en, 0);
            chk("idle_addr", trace_addr, 0);
            chk("idle_pe", predict_enable, 0);
            chk("idle_pc", branch_pc, 0);
            chk("idle_outcome", actual_outcome, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_branches", num_branches, 0);
            chk("idle_mispred", num_mispredictions, 0);
        end else if (m_t <= 3 * m_n) begin
            k  = (m_t - 1) / 3;
            ph = (m_t - 1) % 3;
            chk("run_rd_en", trace_rd_en, ph == 0);
            if (ph == 0) chk("run_addr", trace_addr, k);
            chk("run_pe", predict_enable, ph == 2);
            if (ph == 2) begin
                chk("run_pc", branch_pc, m_pc[k]);
                chk("run_outcome", actual_outcome, m_out[k]);
            end
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_branches", num_branches, sat(k));
            chk("run_mispred", num_mispredictions, sat(m_misb[k]));
        end else begin
            chk("done_rd_en", trace_rd_en, 0);
            chk("done_pe", predict_enable, 0);
            chk("done_busy", busy, 0);
            chk("done_done", done, 1);
            chk("done_branches", num_branches, sat(m_n));
            chk("done_mispred", num_mispredictions, sat(m_misb[m_n]));
            if (m_n > 0) begin
                chk("done_pc_hold", branch_pc, m_pc[m_n-1]);
                chk("done_outcome_hold", actual_outcome, m_out[m_n-1]);
            end
        end
    end

    task automatic go(input int len);
        trace_len = len[ADDR_W:0];
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int mid, output int cyc);
        cyc = 1;
        while (!done && cyc < 200) begin
            if (cyc == mid) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        chk("run_finishes", done, 1);
    endtask

    task automatic wait_done_s(input int mid, output int cyc);
        cyc = 1;
        while (!done_s && cyc < 200) begin
            if (cyc == mid) start_s = 1'b1;
            @(negedge clk);
            start_s = 1'b0;
            cyc++;
        end
        chk("sat_run_finishes", done_s, 1);
    endtask

    initial begin
        int cyc;
        int snap;
        int len;
        int mid;
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        gs_clr = 1'b0;

        // Idle with no start.
        repeat (20) @(negedge clk);
        chk("idle_no_reads", rd_count, 0);
        chk("idle_no_issues", pe_count, 0);

        // Four {10,1} records against a predictor fixed at taken.
        for (int i = 0; i < 4; i++) rom[i] = {PC_W'(10), 1'b1};
        pmode = 0;
        snap  = pe_count;
        go(4);
        wait_done(0, cyc);
        chk("fixed_done_cycle", cyc, 13);
        chk("fixed_branches", num_branches, 4);
        chk("fixed_mispred", num_mispredictions, 0);
        chk("fixed_pe_pulses", pe_count - snap, 4);

        // Same trace against a freshly cleared gshare: every branch misses.
        reset  = 1'b1;
        gs_clr = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        gs_clr = 1'b0;
        pmode  = 2;
        go(4);
        wait_done(0, cyc);
        chk("gshare_branches", num_branches, 4);
        chk("gshare_mispred_lit", num_mispredictions, 4);

        // Zero-length run.
        pmode = 0;
        snap  = rd_count;
        go(0);
        wait_done(0, cyc);
        chk("zero_done_cycle", cyc, 1);
        chk("zero_branches", num_branches, 0);
        chk("zero_no_reads", rd_count - snap, 0);

        // Reset during the ISSUE of record 2 of 5.
        for (int i = 0; i < 5; i++) rom[i] = (PC_W + 1)'($urandom);
        go(5);
        cyc = 1;
        while (cyc < 6) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_in_issue", predict_enable, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_idle_branches", num_branches, 0);
        chk("abort_idle_busy", busy, 0);
        snap = pe_count;
        repeat (10) @(negedge clk);
        chk("abort_no_more_pe", pe_count - snap, 0);

        // Two-bit counters: six mispredicted records, ignored mid-run start, replay.
        for (int i = 0; i < 6; i++) rom[i] = {PC_W'($urandom), 1'b1};
        trace_len_s = 6;
        start_s     = 1'b1;
        @(negedge clk);
        start_s     = 1'b0;
        wait_done_s(7, cyc);
        chk("sat_done_cycle", cyc, 19);
        chk("sat_branches", nb_s, 3);
        chk("sat_mispred", nm_s, 3);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        chk("sat_clear_branches", nb_s, 0);
        chk("sat_clear_mispred", nm_s, 0);
        chk("sat_replay_busy", busy_s, 1);
        wait_done_s(0, cyc);
        chk("sat_replay_done_cycle", cyc, 19);
        chk("sat_replay_branches", nb_s, 3);
        chk("sat_replay_mispred", nm_s, 3);

        // Randomized runs, including clamped lengths and ignored mid-run starts.
        gs_clr = 1'b1;
        @(negedge clk);
        gs_clr = 1'b0;
        for (int r = 0; r < 14; r++) begin
            pmode = $urandom_range(0, 2);
            for (int i = 0; i < DEPTH; i++) rom[i] = (PC_W + 1)'($urandom);
            len = (r == 0) ? 20 : $urandom_range(0, 31);
            mid = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 10) : 0;
            go(len);
            wait_done(mid, cyc);
            chk("rand_branches", num_branches, (len > DEPTH) ? DEPTH : len);
            chk("rand_done_cycle", cyc, 3 * ((len > DEPTH) ? DEPTH : len) + 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/branch_trace_player.md
# branch_trace_player

Synthesizable on-chip stimulus source and scorer for the gshare predictor. It reads packed branch records from a trace memory, presents each record to the predictor's `predict_enable`/`branch_pc`/`actual_outcome` inputs, and samples `prediction` in the same cycle. It counts total branches and mispredictions, so predictor accuracy can be measured on hardware without the simulation file reader.

## Interface
Parameters:
- `PC_W`, 8, branch PC width; must match the predictor.
- `ADDR_W`, 10, trace memory address width (maximum trace length 2^ADDR_W).
- `CNT_W`, 16, width of the statistics counters.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- `trace_len`  in  ADDR_W+1  number of records to play; sampled on accepted `start`.
- `trace_rd_en`  out  1  trace memory read strobe.
- `trace_addr`  out  ADDR_W  trace memory read address.
- `trace_data`  in  PC_W+1  record `{pc, outcome}`, valid exactly one cycle after `trace_rd_en`.
- `predict_enable`  out  1  high for exactly one cycle per branch.
- `branch_pc`  out  PC_W  PC of the branch being presented.
- `actual_outcome`  out  1  resolved direction (1 = taken).
- `prediction`  in  1  predictor output; combinational on `branch_pc` within the issue cycle.
- `busy`  out  1  high in FETCH/WAIT/ISSUE.
- `done`  out  1  level, high in DONE.
- `num_branches`  out  CNT_W  branches issued this run.
- `num_mispredictions`  out  CNT_W  issues where `prediction != actual_outcome`.

## Operation
- FSM states: IDLE, FETCH, WAIT, ISSUE, DONE.
- IDLE/DONE + `start`:
  - latch `trace_len` into `len_q`;
  - clear the index and both counters;
  - go to FETCH if `len_q != 0`, otherwise go directly to DONE (counters stay 0).
- FETCH: assert `trace_rd_en` with `trace_addr = idx`, then go to WAIT.
- WAIT: register `trace_data` into the `branch_pc`/`actual_outcome` registers, then go to ISSUE.
- ISSUE:
  - assert `predict_enable`;
  - compare `prediction` against `actual_outcome`;
  - increment `num_branches`, and `num_mispredictions` on a mismatch;
  - increment `idx`; if `idx+1 == len_q` go to DONE, else go to FETCH.
- Counters saturate at 2^CNT_W-1; they never wrap.
- `start` received in FETCH/WAIT/ISSUE is ignored.
- `branch_pc`/`actual_outcome` hold their last values outside ISSUE. `predict_enable` is 0 outside ISSUE.
- Counters hold their values in DONE until the next accepted `start`.
- `trace_len` larger than 2^ADDR_W is clamped to 2^ADDR_W.

## Timing
- Reset values: state IDLE; `trace_rd_en`, `predict_enable`, `busy` and `done` are 0; `trace_addr`, `branch_pc`, `actual_outcome` and both counters are 0.
- `reset` asserted mid-run forces IDLE on the next edge. The in-flight record is dropped and the predictor sees no further `predict_enable`.
- Throughput is one branch per 3 cycles (FETCH, WAIT, ISSUE).
- First `predict_enable` occurs 3 cycles after the accepted `start` edge.
- A run of N records asserts `done` 3N+1 cycles after `start`. `busy` and `done` are never both high.
- Counter updates are visible the cycle after ISSUE.
- `prediction` is sampled on the same edge at which the predictor trains with `actual_outcome`.

## Structure
- Shared package `bp_pkg`:
  - `PC_W` default;
  - record layout constants `REC_PC_MSB`/`REC_PC_LSB`/`REC_OUT_BIT`;
  - state enum `player_state_t`.
- Sub-module `sat_counter` (parameter width; ports `clk`, `reset`, `clear`, `inc`, `count`), instantiated twice for the two statistics counters.
- Trace memory is external. The bench uses a behavioural ROM with one-cycle read latency.

## Test plan
- Reset then idle: no `start` for 20 cycles -> all outputs 0; `trace_rd_en` and `predict_enable` never assert.
- 4 records `{10,1},{10,1},{10,1},{10,1}` with a stub predictor fixed at 1 -> 4 `predict_enable` pulses spaced 3 cycles apart; `num_branches` = 4; `num_mispredictions` = 0; `done` at cycle 13.
- Same trace with the real gshare after reset -> `num_branches` = 4; `num_mispredictions` equals the bench model's count.
- `trace_len` = 0 -> `done` 1 cycle after `start`; counters 0; no memory reads.
- Reset asserted during the ISSUE of record 2 of 5 -> IDLE next cycle; counters 0; no further `predict_enable`.
- `CNT_W` = 2 with a 6-record all-mispredicted trace -> both counters saturate at 3; `start` pulsed mid-run is ignored; `start` in DONE clears the counters and replays.
